// File: rtl/uart_host_sm.sv
// uart_host_sm: host-side initiator for the UART ALU packet protocol.
// Sends a 4-byte header (opcode, 0x00, len LSB, len MSB) and the payload
// bytes to the UART transmitter, then collects a 4-byte big-endian result
// from the receiver and presents it as a 32-bit word.
module uart_host_sm #(
  parameter int datawidth_p      = 8,
  parameter int timeout_cycles_p = 1000000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [7:0]             cmd_opcode_i,
  input  logic [15:0]            cmd_len_i,
  input  logic [datawidth_p-1:0] op_data_i,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [31:0]            result_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic                   busy_o,
  output logic                   timeout_o
);

  // Idle-cycle counter runs 0 .. timeout_cycles_p-1; the abort fires on the
  // idle cycle that would take it to timeout_cycles_p.
  localparam int TW = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'(timeout_cycles_p - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSendOp,
    StSendRsvd,
    StSendLenLsb,
    StSendLenMsb,
    StSendPayload,
    StRecv,
    StResult
  } state_t;

  state_t        r_state;
  logic [7:0]    r_opcode;
  logic [15:0]   r_len;
  logic [15:0]   r_pay_cnt;
  logic [1:0]    r_idx;
  logic [31:0]   r_shift;
  logic [TW-1:0] r_tcnt;
  logic          r_timeout;

  logic w_tx_hs;
  logic w_rx_hs;

  assign cmd_ready_o    = (r_state == StIdle);
  assign busy_o         = (r_state != StIdle);
  assign rx_ready_o     = (r_state == StRecv);
  assign op_ready_o     = (r_state == StSendPayload) ? tx_ready_i : 1'b0;
  assign result_valid_o = (r_state == StResult);
  assign result_o       = r_shift;
  assign timeout_o      = r_timeout;

  assign w_tx_hs = tx_valid_o && tx_ready_i;
  assign w_rx_hs = rx_valid_i && rx_ready_o;

  // Transmit byte mux: header bytes come from latched registers, payload
  // bytes pass straight through from the operand source.
  always_comb begin
    tx_data_o  = '0;
    tx_valid_o = 1'b0;
    case (r_state)
      StSendOp: begin
        tx_data_o  = datawidth_p'(r_opcode);
        tx_valid_o = 1'b1;
      end
      StSendRsvd: begin
        tx_data_o  = '0;
        tx_valid_o = 1'b1;
      end
      StSendLenLsb: begin
        tx_data_o  = datawidth_p'(r_len[7:0]);
        tx_valid_o = 1'b1;
      end
      StSendLenMsb: begin
        tx_data_o  = datawidth_p'(r_len[15:8]);
        tx_valid_o = 1'b1;
      end
      StSendPayload: begin
        tx_data_o  = op_data_i;
        tx_valid_o = op_valid_i;
      end
      default: begin
        tx_data_o  = '0;
        tx_valid_o = 1'b0;
      end
    endcase
  end

  // Main sequencer: command latch, header/payload send, result collect, timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_opcode  <= '0;
      r_len     <= '0;
      r_pay_cnt <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            r_opcode  <= cmd_opcode_i;
            r_len     <= cmd_len_i;
            r_pay_cnt <= (cmd_len_i < 16'd4) ? 16'd0 : cmd_len_i - 16'd4;
            r_shift   <= '0;
            r_state   <= StSendOp;
          end
        end
        StSendOp: begin
          if (w_tx_hs) r_state <= StSendRsvd;
        end
        StSendRsvd: begin
          if (w_tx_hs) r_state <= StSendLenLsb;
        end
        StSendLenLsb: begin
          if (w_tx_hs) r_state <= StSendLenMsb;
        end
        StSendLenMsb: begin
          if (w_tx_hs) begin
            r_idx  <= '0;
            r_tcnt <= '0;
            r_state <= (r_pay_cnt != 16'd0) ? StSendPayload : StRecv;
          end
        end
        StSendPayload: begin
          if (w_tx_hs) begin
            r_pay_cnt <= r_pay_cnt - 16'd1;
            if (r_pay_cnt == 16'd1) begin
              r_idx   <= '0;
              r_tcnt  <= '0;
              r_state <= StRecv;
            end
          end
        end
        StRecv: begin
          if (w_rx_hs) begin
            // A byte arriving on the limit cycle still wins over the timeout.
            r_shift <= {r_shift[23:0], rx_data_i[7:0]};
            r_idx   <= r_idx + 2'd1;
            r_tcnt  <= '0;
            if (r_idx == 2'd3) r_state <= StResult;
          end else if (r_tcnt == TLIMIT) begin
            r_timeout <= 1'b1;
            r_shift   <= '0;
            r_tcnt    <= '0;
            r_state   <= StIdle;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        StResult: begin
          if (result_ready_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_sm.sv
// Directed bench for uart_host_sm: drives inputs 1 ns after the rising edge,
// checks outputs 2 ns after it or at the falling edge.
module tb_uart_host_sm;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_opcode_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [7:0]  op_data_i = '0;
  logic        op_valid_i = 1'b0;
  logic        op_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        busy_o;
  logic        timeout_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] tx_log[$];
  logic [7:0] pay_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  bit   op_ready_seen = 0;
  bit   rv_seen = 0;
  int   timeout_pulses = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = '0;

  int end_iter;
  int last_rx_iter;

  always #5 clk_i = ~clk_i;

  uart_host_sm #(.datawidth_p(8), .timeout_cycles_p(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_len_i(cmd_len_i),
    .op_data_i(op_data_i), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Falling-edge monitor: logs accepted tx bytes, checks tx hold-while-stalled.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("tx_hold_valid", {31'd0, tx_valid_o}, 32'd1);
        chk("tx_hold_data", {24'd0, tx_data_o}, {24'd0, prev_data});
      end
      if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
      if (op_ready_o) op_ready_seen = 1;
      if (result_valid_o) rv_seen = 1;
      if (timeout_o) timeout_pulses++;
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_cmd(input logic [7:0] op, input logic [15:0] len);
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = op;
    cmd_len_i    = len;
    #1;
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    cyc();
    cmd_valid_i = 1'b0;
  endtask

  // Per-cycle driver for payload and rx sources; stops on result or timeout.
  task automatic run_txn(input bit toggle, input bit gap, input int budget);
    int  op_idx = 0;
    int  rx_idx = 0;
    bit  stall = 0;
    end_iter = -1;
    last_rx_iter = -1;
    for (int i = 0; i < budget; i++) begin
      tx_ready_i = toggle ? i[0] : 1'b1;
      if (op_idx < pay_q.size()) begin
        op_data_i  = pay_q[op_idx];
        op_valid_i = stall || !gap || ((i % 3) != 1);
      end else begin
        op_valid_i = 1'b0;
      end
      if (rx_idx < rx_q.size()) begin
        rx_valid_i = 1'b1;
        rx_data_i  = rx_q[rx_idx];
      end else begin
        rx_valid_i = 1'b0;
      end
      #1;
      if (result_valid_o || timeout_o) begin
        end_iter = i;
        break;
      end
      stall = op_valid_i && !op_ready_o;
      if (op_valid_i && op_ready_o) op_idx++;
      if (rx_valid_i && rx_ready_o) begin
        rx_idx++;
        last_rx_iter = i;
      end
      cyc();
    end
    op_valid_i = 1'b0;
    rx_valid_i = 1'b0;
    chk("txn_in_budget", {31'd0, end_iter >= 0}, 32'd1);
  endtask

  task automatic check_tx(input string tag);
    chk({tag, "_count"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk({tag, "_byte"}, {24'd0, tx_log[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic consume();
    result_ready_i = 1'b1;
    cyc();
    result_ready_i = 1'b0;
    #1;
    chk("idle_after_result", {31'd0, busy_o}, 32'd0);
    chk("rv_low_after_result", {31'd0, result_valid_o}, 32'd0);
  endtask

  initial begin
    // Reset values while rst_i is held.
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("rst_op_ready", {31'd0, op_ready_o}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    cyc();
    rst_i = 1'b0;
    cyc();

    // Add, len=12, full-rate: tx stream, result and minimum latency 9+8.
    tx_log.delete();
    pay_q = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    rx_q  = '{8'h00, 8'h00, 8'h00, 8'h0C};
    issue_cmd(8'h10, 16'd12);
    run_txn(1'b0, 1'b0, 200);
    exp_q = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05,
              8'h00, 8'h00, 8'h00, 8'h07};
    check_tx("add_tx");
    chk("add_result", result_o, 32'h0000000C);
    chk("add_result_valid", {31'd0, result_valid_o}, 32'd1);
    chk("add_latency", end_iter + 1, 32'd17);
    $display("[TB] add len=12 result=%h latency=%0d", result_o, end_iter + 1);
    consume();

    // Mul, tx_ready toggling and gapped operands: same byte order, no drops.
    tx_log.delete();
    pay_q = '{8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h07};
    rx_q  = '{8'h00, 8'h00, 8'h00, 8'h2A};
    issue_cmd(8'h11, 16'd12);
    run_txn(1'b1, 1'b1, 300);
    exp_q = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06,
              8'h00, 8'h00, 8'h00, 8'h07};
    check_tx("stall_tx");
    chk("stall_result", result_o, 32'h0000002A);
    $display("[TB] mul stalled result=%h bytes=%0d", result_o, tx_log.size());
    consume();

    // len=2 clamps to zero payload: header only, op_ready never asserted.
    tx_log.delete();
    pay_q.delete();
    rx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    op_ready_seen = 0;
    issue_cmd(8'h11, 16'd2);
    run_txn(1'b0, 1'b0, 200);
    exp_q = '{8'h11, 8'h00, 8'h02, 8'h00};
    check_tx("clamp_tx");
    chk("clamp_op_ready_never", {31'd0, op_ready_seen}, 32'd0);
    chk("clamp_result", result_o, 32'h12345678);
    chk("clamp_latency", end_iter + 1, 32'd9);
    $display("[TB] len=2 clamp result=%h latency=%0d", result_o, end_iter + 1);
    consume();

    // Timeout: 2 rx bytes then silence; abort after 16 idle cycles.
    tx_log.delete();
    pay_q.delete();
    rx_q = '{8'hAA, 8'hBB};
    rv_seen = 0;
    timeout_pulses = 0;
    issue_cmd(8'h12, 16'd4);
    run_txn(1'b0, 1'b0, 200);
    chk("to_pulse", {31'd0, timeout_o}, 32'd1);
    // Pulse is visible 16 full idle cycles after the cycle the last byte moved.
    chk("to_delay", end_iter - last_rx_iter, 32'd17);
    chk("to_busy", {31'd0, busy_o}, 32'd0);
    cyc();
    #1;
    chk("to_one_cycle", {31'd0, timeout_o}, 32'd0);
    cyc();
    chk("to_pulse_count", timeout_pulses, 32'd1);
    chk("to_no_result", {31'd0, rv_seen}, 32'd0);
    $display("[TB] timeout delay=%0d pulses=%0d", end_iter - last_rx_iter, timeout_pulses);

    // Result back-pressure: value held, pending command waits for handshake.
    tx_log.delete();
    pay_q.delete();
    rx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    issue_cmd(8'h10, 16'd4);
    run_txn(1'b0, 1'b0, 200);
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = 8'h10;
    cmd_len_i    = 16'd8;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, result_valid_o}, 32'd1);
      chk("hold_result", result_o, 32'hDEADBEEF);
      chk("hold_cmd_blocked", {31'd0, cmd_ready_o}, 32'd0);
      cyc();
      #1;
    end
    result_ready_i = 1'b1;
    #1;
    chk("hs_cycle_cmd_blocked", {31'd0, cmd_ready_o}, 32'd0);
    cyc();
    result_ready_i = 1'b0;
    #1;
    chk("after_hs_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("after_hs_rv", {31'd0, result_valid_o}, 32'd0);
    $display("[TB] result hold %h then command accepted", 32'hDEADBEEF);
    cyc();
    cmd_valid_i = 1'b0;
    tx_ready_i  = 1'b1;
    #1;
    chk("new_cmd_opcode", {24'd0, tx_data_o}, 32'h10);
    for (int i = 0; i < 4; i++) cyc();
    op_valid_i = 1'b1;
    op_data_i  = 8'hA5;
    #1;
    chk("pay_passthru", {24'd0, tx_data_o}, 32'hA5);
    chk("pay_op_ready", {31'd0, op_ready_o}, 32'd1);

    // Asynchronous reset mid-cycle during payload: outputs drop at once.
    #1;
    rst_i = 1'b1;
    #1;
    chk("arst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("arst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("arst_tx_data", {24'd0, tx_data_o}, 32'd0);
    chk("arst_op_ready", {31'd0, op_ready_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    $display("[TB] async reset during payload");
    op_valid_i = 1'b0;
    cyc();
    rst_i = 1'b0;
    cyc();

    // Clean restart after reset.
    tx_log.delete();
    pay_q = '{8'h33};
    rx_q  = '{8'h00, 8'h00, 8'h00, 8'h01};
    issue_cmd(8'h10, 16'd5);
    run_txn(1'b0, 1'b0, 200);
    exp_q = '{8'h10, 8'h00, 8'h05, 8'h00, 8'h33};
    check_tx("restart_tx");
    chk("restart_result", result_o, 32'h00000001);
    $display("[TB] restart result=%h", result_o);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_host_sm.md
Name: uart_host_sm

Overview:
- Host-side initiator for the UART ALU packet protocol.
- Accepts a command (opcode, length) plus an operand byte stream and serializes the packet toward the UART transmitter.
- Packet format: opcode, reserved 0x00, length LSB, length MSB, then payload bytes.
- Collects the 4-byte big-endian result returned by the ALU end and presents it as a 32-bit word.
- Sits between a command source (on-chip master or self-test driver) and the uart_tx/uart_rx byte interfaces.

Parameters:
datawidth_p, 8, UART byte width; fixed at 8 for this protocol.
timeout_cycles_p, 1000000, maximum idle cycles allowed between result bytes before the transaction is aborted; must be >= 1.

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  command accepted on cmd_valid_i && cmd_ready_o
cmd_opcode_i  input  8  opcode (0x10 add, 0x11 mul, 0x12 div)
cmd_len_i  input  16  total packet length in bytes, including the 4-byte header
op_data_i  input  8  payload byte
op_valid_i  input  1  payload byte present
op_ready_o  output  1  payload byte consumed on op_valid_i && op_ready_o
tx_data_o  output  8  byte to UART transmitter
tx_valid_o  output  1  tx byte present
tx_ready_i  input  1  transmitter accepts byte
rx_data_i  input  8  byte from UART receiver
rx_valid_i  input  1  rx byte present
rx_ready_o  output  1  rx byte accepted on rx_valid_i && rx_ready_o
result_o  output  32  assembled result
result_valid_o  output  1  result_o valid
result_ready_i  input  1  consumer accepts result
busy_o  output  1  high in every state except StIdle
timeout_o  output  1  one-cycle pulse when a transaction is aborted for timeout

Behaviour:
- Reset (async, rst_i=1): state StIdle.
  - Outputs: cmd_ready_o=1, tx_valid_o=0, tx_data_o=0, op_ready_o=0, rx_ready_o=0, result_o=0, result_valid_o=0, busy_o=0, timeout_o=0.
  - Clears all internal registers.
  - Reset asserted mid-transaction discards everything; no partial result is ever presented.
- Handshakes: a byte transfers only on the cycle valid && ready are both high. Senders hold data stable while valid && !ready.
- StIdle:
  - cmd_ready_o=1.
  - On cmd handshake: latch opcode and len; payload count = (len < 4) ? 0 : len-4. Go to StSendOp.
- Header states StSendOp, StSendRsvd, StSendLenLsb, StSendLenMsb:
  - tx_valid_o=1.
  - tx_data_o driven from latched registers: opcode, 0x00, len[7:0], len[15:8] respectively.
  - Advance one state per tx handshake.
  - After StSendLenMsb: go to StSendPayload if payload count != 0, else StRecv.
- StSendPayload (combinational pass-through):
  - tx_data_o=op_data_i, tx_valid_o=op_valid_i, op_ready_o=tx_ready_i.
  - Payload counter decrements on each handshake; go to StRecv on the handshake that reaches 0.
  - op_ready_o=0 in all other states.
- StRecv:
  - rx_ready_o=1.
  - 2-bit byte index starting at 0. Each rx handshake shifts into a result shift register, MSB first: first byte -> result[31:24], fourth byte -> result[7:0].
  - On the 4th byte: go to StResult.
  - rx_ready_o=0 outside StRecv; rx bytes arriving in other states are not accepted.
- Timeout in StRecv:
  - Counter clears on entry and on each rx handshake; otherwise increments.
  - When it reaches timeout_cycles_p with no handshake that cycle: pulse timeout_o for 1 cycle, go to StIdle, result_valid_o stays 0.
  - An rx handshake in the same cycle as the limit wins: byte accepted, no timeout.
- StResult:
  - result_valid_o=1 and result_o held stable until result_ready_i.
  - On handshake: go to StIdle.
  - cmd_ready_o=0 until back in StIdle; a new command is never accepted in the same cycle a result is consumed.
- Latency: minimum cycles from cmd handshake to result_valid_o = 4 + payload + 4 + 1, with all readies/valids held high.
- Widths: len is unsigned 16-bit; payload counter is 16-bit; len=0xFFFF gives 65531 payload bytes.

Test Plan:
- Add, len=12, payload 00 00 00 05 00 00 00 07 with tx_ready_i=1 -> tx stream 10 00 0C 00 00 00 00 05 00 00 00 07. Then rx 00 00 00 0C -> result_o=0x0000000C, result_valid_o=1.
- tx_ready_i toggled 1/0 every cycle, op_valid_i gapped -> identical byte sequence, no drops or duplicates, tx_data_o stable while stalled.
- len=2 (clamped) -> exactly 4 header bytes 11 00 02 00, op_ready_o never high, then StRecv.
- timeout_cycles_p=16: send 2 rx bytes then silence -> timeout_o pulses once 16 cycles after the last byte, busy_o falls, result_valid_o never rises.
- result_ready_i held 0 for 10 cycles -> result_valid_o and result_o=0xDEADBEEF held; cmd_valid_i=1 not accepted until the cycle after the result handshake.
- rst_i asserted during StSendPayload, asynchronously mid-cycle -> all outputs go to reset values immediately; a following command restarts cleanly from the opcode byte.
